// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU: latches two WIDTH-bit operands, computes one nibble per
// clock LSB first, then presents the result with Z80-style flags under start/busy/done.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one nibble pass per clock, busy high
// DONE   | result/flags valid for one cycle, start accepted here too
module alu_nibble_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             hf,
  output logic             pf,
  output logic             zf,
  output logic             sf,
  output logic             vf
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             carry_q;
  logic             par_q;
  logic             hc_q;
  logic [WIDTH-5:0] work_q;

  logic             sub_op;
  logic             sub_q;
  logic             logic_q;
  logic             init_carry;
  logic             accept;
  logic             last;
  logic [3:0]       a_n;
  logic [3:0]       b_n;
  logic [4:0]       sum;
  logic [3:0]       nib_res;
  logic             carry_out;
  logic             c_msb_in;
  logic             half;
  logic             par_next;
  logic [WIDTH-1:0] r_full;
  logic [WIDTH-1:0] a_rot;
  logic [WIDTH-1:0] b_rot;

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_comb begin
    sub_op = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    init_carry = 1'b0;
    case (op)
      OP_ADC:         init_carry = cin;
      OP_SUB, OP_CP:  init_carry = 1'b1;
      OP_SBC:         init_carry = ~cin;
      default:        init_carry = 1'b0;
    endcase
    accept = start && (state != S_CALC);
  end

  // Operands rotate one nibble per pass so the active nibble is always [3:0];
  // after NIB rotations a_q is back to the original value, which CP returns.
  always_comb begin
    sub_q    = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    logic_q  = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
    last     = (cnt == CW'(NIB - 1));
    a_n      = a_q[3:0];
    b_n      = b_q[3:0];
    sum      = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, carry_q};
    carry_out = sum[4];
    c_msb_in = a_n[3] ^ b_n[3] ^ sum[3];
    nib_res  = sum[3:0];
    case (op_q)
      OP_AND:  nib_res = a_n & b_n;
      OP_XOR:  nib_res = a_n ^ b_n;
      OP_OR:   nib_res = a_n | b_n;
      default: nib_res = sum[3:0];
    endcase
    half     = (cnt == '0) ? carry_out : hc_q;
    par_next = par_q ^ (^nib_res);
    r_full   = {nib_res, work_q};
    a_rot    = {a_q[3:0], a_q[WIDTH-1:4]};
    b_rot    = {b_q[3:0], b_q[WIDTH-1:4]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      par_q   <= 1'b0;
      hc_q    <= 1'b0;
      work_q  <= '0;
      result  <= '0;
      cf      <= 1'b0;
      hf      <= 1'b0;
      pf      <= 1'b0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      vf      <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          a_q     <= a_rot;
          b_q     <= b_rot;
          work_q  <= r_full[WIDTH-1:4];
          carry_q <= carry_out;
          par_q   <= par_next;
          if (cnt == '0) hc_q <= carry_out;
          if (last) begin
            state  <= S_DONE;
            cnt    <= '0;
            result <= (op_q == OP_CP) ? a_rot : r_full;
            pf     <= ~par_next;
            zf     <= (r_full == '0);
            sf     <= r_full[WIDTH-1];
            if (logic_q) begin
              cf <= 1'b0;
              vf <= 1'b0;
              hf <= (op_q == OP_AND);
            end else begin
              // Subtraction runs as a + ~b + 1, so borrow is the missing carry.
              cf <= sub_q ? ~carry_out : carry_out;
              hf <= sub_q ? ~half : half;
              vf <= c_msb_in ^ carry_out;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (accept) begin
            state   <= S_CALC;
            cnt     <= '0;
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub_op}};
            op_q    <= op;
            carry_q <= init_carry;
            par_q   <= 1'b0;
            hc_q    <= 1'b0;
            work_q  <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Parametrised nibble-serial arithmetic/logic sequencer, the multi-width successor to the 8-bit two-pass nibble ALU. It latches two WIDTH-bit operands and computes the result one 4-bit nibble per clock, LSB nibble first, rippling carry and parity between passes. It then presents the result with a Z80-style flag set under a start/busy/done handshake. It sits beside the core ALU datapath for multi-byte (16/32-bit) operations.

## Interface
- WIDTH, 8, operand/result width in bits; multiple of 4, range 8..32
- NIB (localparam), WIDTH/4, number of nibble passes
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled on rising clk when not busy
- op  input  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- a  input  WIDTH  operand 1, latched on accepting edge
- b  input  WIDTH  operand 2, latched on accepting edge
- cin  input  1  carry in for ADC/SBC, latched on accepting edge
- busy  output  1  high while nibble passes are in progress
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH  registered result, held until next completion
- cf, hf, pf, zf, sf, vf  output  1 each  carry/borrow, half-carry, even parity, zero, sign, signed overflow

## Operation
- States: IDLE, CALC, DONE. Nibble counter 0..NIB-1 (width clog2(NIB), minimum 1).
- IDLE or DONE with start=1: latch a, b, op, cin; counter=0; -> CALC. DONE with start=0 -> IDLE.
- CALC: each cycle processes nibble k = counter: a[4k+3:4k] with b nibble (complemented for SUB/SBC/CP) and running carry; writes result nibble k into working register; updates running parity; counter++. At counter = NIB-1 -> DONE, outputs registered.
- Initial carry: ADD 0, ADC cin, SUB/CP 1, SBC ~cin. Carry into nibble k+1 = carry out of nibble k.
- Logic ops: per nibble bitwise, no carry chain.
- CP: computes a-b for flags; result output = latched a.
- Flags at completion (R = computed value, difference for CP):
  - cf: arith = carry out of MSB (add) / inverted carry out (borrow, sub); logic = 0.
  - hf: arith = carry/borrow out of nibble 0 (bit 3); AND = 1; OR/XOR = 0.
  - pf: 1 when R has an even number of ones (all ops).
  - zf: R == 0. sf: R[WIDTH-1].
  - vf: arith = signed overflow (carry into MSB xor carry out of MSB); logic = 0.
- start while busy (CALC) ignored; in-flight operation unaffected.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset: state IDLE, counter 0, busy 0, done 0, result 0, all flags 0. Asynchronous; effective immediately.
- Reset mid-CALC aborts; done is not asserted for the aborted op; outputs read 0.
- Accepting edge E0; busy high from E0 to edge E(NIB); done high for exactly the one cycle after E(NIB). Latency start->done = NIB clocks (2 for WIDTH=8, 4 for 16, 8 for 32).
- result and flags update only at E(NIB); stable through done and after it until the next completion.
- Back-to-back: start during the done cycle accepted; busy rises on that edge, no idle gap; throughput one op per NIB+1 cycles.
- busy and done never high simultaneously.

## Test plan
- WIDTH=8, ADD a=8C b=6D -> done 2 clocks after start, result F9, cf0 hf1 pf1 zf0 sf1 vf0.
- WIDTH=8, SUB a=00 b=01 -> result FF, cf1 hf1 vf0 sf1 zf0 pf1; ADD 7F+01 -> 80, vf1 hf1 cf0 sf1.
- WIDTH=16, ADC a=FFFF b=0000 cin=1 -> busy 4 cycles, result 0000, cf1 hf1 zf1 vf0 pf1.
- WIDTH=8, AND F0&0F -> 00, zf1 hf1 cf0 pf1 vf0; CP a=42 b=42 -> result 42, zf1 cf0 sf0.
- WIDTH=32, start pulsed again during CALC with different operands -> ignored; original result delivered after 8 clocks; start in done cycle -> second op completes 8 clocks later.
- Reset asserted mid-CALC (WIDTH=16, counter=2) -> outputs 0 immediately, no done pulse; next start after release completes normally.
